// File: rtl/i2c_seq_pkg.sv
// Shared definitions for the I2C write sequencer and the host command decoder:
// state codes, default engine timing and the 32-bit to 2x16 data split.
package i2c_seq_pkg;
   localparam logic [2:0] ST_FLUSH  = 3'd0;
   localparam logic [2:0] ST_IDLE   = 3'd1;
   localparam logic [2:0] ST_ASSERT = 3'd2;
   localparam logic [2:0] ST_FRAME  = 3'd3;
   localparam logic [2:0] ST_GAP    = 3'd4;

   localparam int DEF_DIV_LOG2   = 15;
   localparam int DEF_FRAME_BITS = 168;
   localparam int DEF_HOLD_TICKS = 3;
   localparam int DEF_SYNC_TICKS = 2;
   localparam int DEF_GAP_TICKS  = 4;
   localparam int TICK_W         = 9;

   // Upper half of the request word is sent first (engine DATA12).
   function automatic logic [15:0] data12(input logic [31:0] d);
      return d[31:16];
   endfunction

   function automatic logic [15:0] data34(input logic [31:0] d);
      return d[15:0];
   endfunction
endpackage

// File: rtl/i2c_tick_timer.sv
// Prescaler plus tick counter; done pulses on the last CLK of the limit-th tick.
module i2c_tick_timer
   import i2c_seq_pkg::*;
#(
   parameter int DIV_LOG2 = DEF_DIV_LOG2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              restart,
   input  logic [TICK_W-1:0] limit,
   output logic              done
);
   logic [DIV_LOG2-1:0] pre;
   logic [TICK_W-1:0]   cnt;
   logic                tick;

   assign tick = &pre;
   assign done = tick && (cnt == limit - TICK_W'(1));

   always_ff @(posedge clk) begin
      if (rst || restart) begin
         pre <= '0;
         cnt <= '0;
      end else begin
         pre <= pre + DIV_LOG2'(1);
         if (tick) cnt <= cnt + TICK_W'(1);
      end
   end
endmodule

// File: rtl/i2c_write_sequencer.sv
// Round-robin front end for the 4-byte I2C writer engine; times each frame
// slot itself since the engine exposes no busy indication.
module i2c_write_sequencer
   import i2c_seq_pkg::*;
#(
   parameter int DIV_LOG2   = DEF_DIV_LOG2,
   parameter int FRAME_BITS = DEF_FRAME_BITS,
   parameter int HOLD_TICKS = DEF_HOLD_TICKS,
   parameter int SYNC_TICKS = DEF_SYNC_TICKS,
   parameter int GAP_TICKS  = DEF_GAP_TICKS
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        REQ0_VALID,
   output logic        REQ0_READY,
   input  logic [1:0]  REQ0_LINES,
   input  logic [31:0] REQ0_DATA,
   input  logic        REQ1_VALID,
   output logic        REQ1_READY,
   input  logic [1:0]  REQ1_LINES,
   input  logic [31:0] REQ1_DATA,
   output logic [1:0]  REQ_DONE,
   output logic        BUSY,
   output logic        I2C_ENABLE,
   output logic [1:0]  I2C_LINES,
   output logic [15:0] I2C_DATA12,
   output logic [15:0] I2C_DATA34
);
   logic [2:0]        state, state_nxt;
   logic              owner, ptr;
   logic [TICK_W-1:0] limit;
   logic              done, grant0, grant1, accept;

   // ptr holds the last served requester; the other one wins a tie.
   assign grant0 = (state == ST_IDLE) && REQ0_VALID && (!REQ1_VALID || ptr);
   assign grant1 = (state == ST_IDLE) && REQ1_VALID && (!REQ0_VALID || !ptr);
   assign accept = grant0 || grant1;

   assign REQ0_READY = grant0;
   assign REQ1_READY = grant1;
   assign BUSY       = (state != ST_IDLE);
   assign I2C_ENABLE = (state == ST_ASSERT);

   always_comb begin
      limit     = '0;
      state_nxt = state;
      case (state)
         ST_FLUSH: begin
            limit = TICK_W'(HOLD_TICKS + FRAME_BITS + SYNC_TICKS);
            if (done) state_nxt = ST_IDLE;
         end
         ST_IDLE:
            if (accept) state_nxt = ST_ASSERT;
         ST_ASSERT: begin
            limit = TICK_W'(HOLD_TICKS);
            if (done) state_nxt = ST_FRAME;
         end
         ST_FRAME: begin
            limit = TICK_W'(FRAME_BITS + SYNC_TICKS);
            if (done) state_nxt = ST_GAP;
         end
         ST_GAP: begin
            limit = TICK_W'(GAP_TICKS);
            if (done) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_FLUSH;
      endcase
   end

   i2c_tick_timer #(.DIV_LOG2(DIV_LOG2)) u_timer (
      .clk     (CLK),
      .rst     (RST),
      .restart (state_nxt != state),
      .limit   (limit),
      .done    (done)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= ST_FLUSH;
         ptr        <= 1'b1;
         owner      <= 1'b0;
         REQ_DONE   <= 2'b00;
         I2C_LINES  <= 2'b00;
         I2C_DATA12 <= '0;
         I2C_DATA34 <= '0;
      end else begin
         state    <= state_nxt;
         REQ_DONE <= 2'b00;
         if (accept) begin
            owner      <= grant1;
            ptr        <= grant1;
            I2C_LINES  <= grant1 ? REQ1_LINES : REQ0_LINES;
            I2C_DATA12 <= data12(grant1 ? REQ1_DATA : REQ0_DATA);
            I2C_DATA34 <= data34(grant1 ? REQ1_DATA : REQ0_DATA);
         end
         if (state == ST_GAP && done) REQ_DONE <= owner ? 2'b10 : 2'b01;
      end
   end
endmodule

// File: tb/tb_i2c_write_sequencer.sv
// Randomized bench with a slot-level reference model (DIV_LOG2=2, tick = 4 CLK).
module tb_i2c_write_sequencer;
   localparam int FLUSH_CYC = (3 + 168 + 2) * 4;          // 692
   localparam int SLOT_CYC  = (3 + 168 + 2 + 4) * 4 + 1;  // 709: accept to next possible accept
   localparam int EN_CYC    = 3 * 4;                      // 12

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        REQ0_VALID = 1'b0, REQ1_VALID = 1'b0;
   logic        REQ0_READY, REQ1_READY;
   logic [1:0]  REQ0_LINES = '0, REQ1_LINES = '0;
   logic [31:0] REQ0_DATA = '0, REQ1_DATA = '0;
   logic [1:0]  REQ_DONE;
   logic        BUSY, I2C_ENABLE;
   logic [1:0]  I2C_LINES;
   logic [15:0] I2C_DATA12, I2C_DATA34;

   i2c_write_sequencer #(
      .DIV_LOG2(2), .FRAME_BITS(168), .HOLD_TICKS(3), .SYNC_TICKS(2), .GAP_TICKS(4)
   ) dut (
      .CLK(CLK), .RST(RST),
      .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY), .REQ0_LINES(REQ0_LINES), .REQ0_DATA(REQ0_DATA),
      .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY), .REQ1_LINES(REQ1_LINES), .REQ1_DATA(REQ1_DATA),
      .REQ_DONE(REQ_DONE), .BUSY(BUSY), .I2C_ENABLE(I2C_ENABLE),
      .I2C_LINES(I2C_LINES), .I2C_DATA12(I2C_DATA12), .I2C_DATA34(I2C_DATA34)
   );

   always #5 CLK = ~CLK;

   int n_chk = 0, n_err = 0;
   int cyc = 0;
   int mode = 0;
   logic armed = 1'b0;

   // reference model: the slot timeline of the last accept
   int         idle_from = 0;
   int         acc_t = -100000;
   int         done_at = -1;
   logic       acc_live = 1'b0;
   logic       owner_m = 1'b0;
   logic       last_m = 1'b1;
   logic [1:0] lines_m = '0;
   logic [31:0] data_m = '0;
   int         n_acc0 = 0, n_acc1 = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   always @(posedge CLK) cyc <= cyc + 1;

   // stimulus, driven just after each rising edge
   always @(posedge CLK) begin
      #1;
      case (mode)
         1: begin
            REQ0_VALID = 1'b1; REQ0_LINES = 2'b01; REQ0_DATA = 32'hA5C3_1E7F;
            REQ1_VALID = 1'b0;
         end
         2: begin
            REQ0_VALID = 1'b1; REQ0_LINES = 2'($urandom); REQ0_DATA = $urandom;
            REQ1_VALID = 1'b1; REQ1_LINES = 2'($urandom); REQ1_DATA = $urandom;
         end
         3: begin
            REQ0_VALID = ($urandom_range(0, 7) == 0); REQ0_LINES = 2'($urandom); REQ0_DATA = $urandom;
            REQ1_VALID = ($urandom_range(0, 7) == 0); REQ1_LINES = 2'($urandom); REQ1_DATA = $urandom;
         end
         4: begin
            REQ0_VALID = 1'b0;
            REQ1_VALID = 1'b1; REQ1_LINES = 2'b00; REQ1_DATA = $urandom;
         end
         default: begin
            REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
         end
      endcase
   end

   // check outputs mid-cycle, then advance the model to the next edge
   always @(negedge CLK) begin
      logic busy_e, en_e, g0, g1;
      logic [1:0] done_e;
      busy_e = (cyc < idle_from);
      en_e   = acc_live && (cyc >= acc_t + 1) && (cyc <= acc_t + EN_CYC);
      done_e = (cyc == done_at) ? (owner_m ? 2'b10 : 2'b01) : 2'b00;
      g0 = !busy_e && REQ0_VALID && (!REQ1_VALID || last_m);
      g1 = !busy_e && REQ1_VALID && (!REQ0_VALID || !last_m);
      if (armed) begin
         chk("busy",   32'(BUSY),       32'(busy_e));
         chk("enable", 32'(I2C_ENABLE), 32'(en_e));
         chk("done",   32'(REQ_DONE),   32'(done_e));
         chk("ready0", 32'(REQ0_READY), 32'(g0));
         chk("ready1", 32'(REQ1_READY), 32'(g1));
         chk("lines",  32'(I2C_LINES),  32'(lines_m));
         chk("data",   {I2C_DATA12, I2C_DATA34}, data_m);
      end
      if (RST) begin
         armed     = 1'b1;
         idle_from = cyc + 1 + FLUSH_CYC;
         acc_live  = 1'b0;
         done_at   = -1;
         last_m    = 1'b1;
         lines_m   = '0;
         data_m    = '0;
      end else if (armed && (g0 || g1)) begin
         acc_t     = cyc;
         acc_live  = 1'b1;
         owner_m   = g1;
         last_m    = g1;
         lines_m   = g1 ? REQ1_LINES : REQ0_LINES;
         data_m    = g1 ? REQ1_DATA : REQ0_DATA;
         idle_from = cyc + SLOT_CYC;
         done_at   = cyc + SLOT_CYC;
         if (g1) n_acc1++; else n_acc0++;
      end
   end

   initial begin
      logic found;
      int a0, a1;
      RST = 1'b1;
      repeat (3) @(posedge CLK);
      #1 RST = 1'b0;

      // FLUSH with requester 0 waiting, then fixed-data slots
      mode = 1;
      repeat (FLUSH_CYC + 3 * SLOT_CYC + 40) @(posedge CLK);

      // both valid: strict alternation, data changing every cycle
      a0 = n_acc0; a1 = n_acc1;
      mode = 2;
      repeat (4 * SLOT_CYC + 20) @(posedge CLK);
      chk("rr_split", 32'((n_acc0 - a0) - (n_acc1 - a1) + 1), 32'(1));

      // sparse random requests, VALID dropping before accept
      mode = 3;
      repeat (4 * SLOT_CYC) @(posedge CLK);

      // reset in the middle of a FRAME
      mode = 1;
      found = 1'b0;
      for (int i = 0; i < 3 * SLOT_CYC && !found; i++) begin
         @(negedge CLK);
         if (acc_live && cyc == acc_t + 200) found = 1'b1;
      end
      chk("rst_wait", 32'(found), 32'(1));
      @(posedge CLK); #1 RST = 1'b1;
      @(posedge CLK); #1 RST = 1'b0;
      repeat (FLUSH_CYC + SLOT_CYC + 20) @(posedge CLK);

      // LINES=00 from requester 1
      mode = 4;
      repeat (2 * SLOT_CYC + 20) @(posedge CLK);

      mode = 0;
      repeat (50) @(posedge CLK);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/i2c_write_sequencer.md
Name: i2c_write_sequencer

Overview:
- Controller in front of the brute-force 4-byte I2C writer engine.
- Accepts 32-bit I2C write requests from two requesters (0 = ESP32 host command path, 1 = on-chip init/monitor logic) and arbitrates between them round-robin.
- Drives the engine's ENABLE, line-select and data inputs. The engine has no busy output, so the block times each frame with its own counters, keeping frames serialised and data stable.

Parameters:
- DIV_LOG2, 15: log2 of CLK cycles per engine bit tick. Must match the engine's clock divider.
- FRAME_BITS, 168: engine frame length in ticks.
- HOLD_TICKS, 3: ticks that ENABLE is held high.
- SYNC_TICKS, 2: slack for the engine's 2-stage ENABLE sync and unknown divider phase.
- GAP_TICKS, 4: idle ticks between frames, with ENABLE low.

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous, active-high reset
- REQ0_VALID  in  1  requester 0 has a write pending
- REQ0_READY  out  1  requester 0 accepted this cycle when VALID&READY
- REQ0_LINES  in  2  bus select for requester 0
- REQ0_DATA  in  32  bytes for requester 0; [31:16] go to DATA12, [15:0] go to DATA34
- REQ1_VALID, REQ1_READY, REQ1_LINES, REQ1_DATA: same as requester 0, for requester 1
- REQ_DONE  out  2  one-cycle pulse per requester when its frame slot completes
- BUSY  out  1  high in every state except IDLE
- I2C_ENABLE  out  1  to engine ENABLE
- I2C_LINES  out  2  to engine I2CLINES
- I2C_DATA12  out  16  to engine I2CDATA12
- I2C_DATA34  out  16  to engine I2CDATA34

Behaviour:
- Timing base:
  - Free-running tick prescaler of DIV_LOG2 bits.
  - Restarted at 0 on every state entry, so phase counts are exact: one tick = 2^DIV_LOG2 CLK cycles.
  - Tick counter is 9 bits and is cleared on state entry.
- States: FLUSH, IDLE, ASSERT, FRAME, GAP.
- RST, including mid-operation:
  - Next state is FLUSH.
  - I2C_ENABLE=0, I2C_LINES=0, I2C_DATA*=0, READY=0, REQ_DONE=0, BUSY=1.
  - RR pointer set so requester 0 wins the first tie.
- FLUSH:
  - Waits HOLD_TICKS+FRAME_BITS+SYNC_TICKS ticks with ENABLE low, so any engine frame already in flight ends.
  - Then goes to IDLE. No REQ_DONE is issued.
- IDLE:
  - READYx = VALIDx & grant(x), combinational from registered state and pointer.
  - Grant: if only one requester is valid, grant it. If both are valid, grant the one not served last.
  - On accept: latch LINES/DATA into the output registers, record the owner, flip the pointer to the owner, go to ASSERT.
  - At most one READY is high per cycle.
- ASSERT:
  - I2C_ENABLE=1 for exactly HOLD_TICKS ticks.
  - Guarantees at least 2 engine-clock samples high, so exactly one rising edge is detected.
- FRAME: I2C_ENABLE=0 for FRAME_BITS+SYNC_TICKS ticks.
- GAP:
  - Runs for GAP_TICKS ticks.
  - On exit: REQ_DONE[owner]=1 for one cycle, same cycle as IDLE entry.
- Output stability:
  - I2C_LINES and I2C_DATA* hold the latched values from accept until the next accept.
  - They never change between ASSERT entry and GAP exit.
- LINES=2'b00: accepted and timed normally (the engine drives nothing); no error path.
- A VALID dropped before acceptance is not recorded.
- No back-to-back accept: minimum spacing is the full slot, (HOLD+FRAME+SYNC+GAP) ticks + 1 cycle.
- Requester inputs are ignored outside IDLE.

Decomposition:
- Shared package i2c_seq_pkg: state enum (FLUSH/IDLE/ASSERT/FRAME/GAP), default timing constants, and the 32-to-2x16 data split convention, shared with the host command decoder.
- One natural sub-module, i2c_tick_timer: prescaler plus tick counter with restart and terminal-count outputs.
- The RR arbiter stays inline.

Test Plan:
All scenarios use DIV_LOG2=2 (tick = 4 CLK), FRAME_BITS=168, HOLD=3, SYNC=2, GAP=4.
1. After RST deassert:
   - REQ0_VALID=1 held; REQ0_READY stays 0 for 173 ticks (692 cycles) in FLUSH.
   - Then it is accepted; BUSY=1 throughout FLUSH.
2. Single request, REQ0_DATA=32'hA5C3_1E7F, LINES=2'b01, accepted at edge T:
   - I2C_DATA12=16'hA5C3, I2C_DATA34=16'h1E7F, I2C_LINES=01 from T+1.
   - I2C_ENABLE high for exactly cycles T+1..T+12.
   - REQ_DONE=2'b01 is a single pulse at cycle T+709; BUSY falls the same cycle.
3. Both VALID continuously:
   - Grants alternate 0,1,0,1.
   - REQ_DONE bits alternate.
   - No two ENABLE pulses are closer than 708 cycles.
4. RST asserted mid-FRAME:
   - Next cycle: I2C_ENABLE=0, outputs zero, READY=0, no REQ_DONE pulse for the aborted owner.
   - A full FLUSH elapses before the next grant.
5. Stability: REQ1_DATA changes every cycle after acceptance → I2C_DATA* is unchanged until the next accept.
6. LINES=2'b00 request → normal 708-cycle slot and REQ_DONE pulse; I2C_LINES=00 throughout.
